// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide sequencer.
// DIV/DIVU are only counted as multi-cycle ops when MDU_DIV_EN is defined.
package mdu_pkg;

   localparam int unsigned MDU_OP_W         = 3;
   localparam int unsigned MDU_XLEN         = 32;
   localparam int unsigned MDU_MULT_LAT_DEF = 5;
   localparam int unsigned MDU_DIV_LAT_DEF  = 10;

   typedef enum logic [MDU_OP_W-1:0] {
      MDU_NOP   = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6,
      MDU_RSVD  = 3'd7
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // True for ops that occupy the unit for a latency period
   function automatic logic is_multicycle(input logic [MDU_OP_W-1:0] op);
      logic r;
      r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_DIV_EN
      r = r || (op == MDU_DIV) || (op == MDU_DIVU);
`endif
      return r;
   endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Combinational product and quotient/remainder from the latched operands.
// Divider ports and logic exist only when MDU_DIV_EN is defined.
module mdu_datapath
   import mdu_pkg::*;
(
   input  logic [MDU_OP_W-1:0]   op_i,
   input  logic [MDU_XLEN-1:0]   a_i,
   input  logic [MDU_XLEN-1:0]   b_i,
   output logic [2*MDU_XLEN-1:0] prod_o
`ifdef MDU_DIV_EN
   ,
   output logic [MDU_XLEN-1:0]   quot_o,
   output logic [MDU_XLEN-1:0]   rem_o,
   output logic                  div_zero_o
`endif
);

   logic                  mul_signed;
   logic [2*MDU_XLEN-1:0] a_ext;
   logic [2*MDU_XLEN-1:0] b_ext;

   // Sign- or zero-extend to 64 bits so one multiplier serves MULT and MULTU
   always_comb begin
      mul_signed = (op_i == MDU_MULT);
      a_ext      = {{MDU_XLEN{mul_signed & a_i[MDU_XLEN-1]}}, a_i};
      b_ext      = {{MDU_XLEN{mul_signed & b_i[MDU_XLEN-1]}}, b_i};
      prod_o     = a_ext * b_ext;
   end

`ifdef MDU_DIV_EN
   logic                a_neg;
   logic                b_neg;
   logic [MDU_XLEN-1:0] a_mag;
   logic [MDU_XLEN-1:0] b_mag;
   logic [MDU_XLEN-1:0] b_safe;
   logic [MDU_XLEN-1:0] q_mag;
   logic [MDU_XLEN-1:0] r_mag;

   // Divide magnitudes, then restore signs; this also gives 0x80000000 / -1 = 0x80000000 rem 0
   always_comb begin
      a_neg      = (op_i == MDU_DIV) & a_i[MDU_XLEN-1];
      b_neg      = (op_i == MDU_DIV) & b_i[MDU_XLEN-1];
      a_mag      = a_neg ? -a_i : a_i;
      b_mag      = b_neg ? -b_i : b_i;
      div_zero_o = (b_i == '0);
      b_safe     = div_zero_o ? MDU_XLEN'(1) : b_mag;
      q_mag      = a_mag / b_safe;
      r_mag      = a_mag % b_safe;
      quot_o     = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem_o      = a_neg ? -r_mag : r_mag;
   end
`endif

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO multiply/divide unit: IDLE/RUN sequencer, latency counter and HI/LO registers.
// Define MDU_DIV_EN to implement DIV/DIVU; otherwise ops 3/4 behave as NOP.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_LAT = MDU_MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = MDU_DIV_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [MDU_OP_W-1:0] op,
   input  logic [MDU_XLEN-1:0] rs_val,
   input  logic [MDU_XLEN-1:0] rt_val,
   input  logic                cancel,
   input  logic                md_use_d,
   output logic                busy,
   output logic                stall,
   output logic [MDU_XLEN-1:0] hi_out,
   output logic [MDU_XLEN-1:0] lo_out
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

   mdu_state_e          state_q, state_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MDU_OP_W-1:0] op_q, op_d;
   logic [MDU_XLEN-1:0] a_q, a_d;
   logic [MDU_XLEN-1:0] b_q, b_d;
   logic [MDU_XLEN-1:0] hi_q, hi_d;
   logic [MDU_XLEN-1:0] lo_q, lo_d;

   logic [2*MDU_XLEN-1:0] prod;
`ifdef MDU_DIV_EN
   logic [MDU_XLEN-1:0]   quot;
   logic [MDU_XLEN-1:0]   rem;
   logic                  div_zero;
`endif

   mdu_datapath u_datapath (
      .op_i       (op_q),
      .a_i        (a_q),
      .b_i        (b_q),
      .prod_o     (prod)
`ifdef MDU_DIV_EN
      ,
      .quot_o     (quot),
      .rem_o      (rem),
      .div_zero_o (div_zero)
`endif
   );

   // Next-state: accept in IDLE, count down in RUN, write HI/LO as RUN completes
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !cancel) begin
               if (is_multicycle(op)) begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
                  op_d    = op;
                  a_d     = rs_val;
                  b_d     = rt_val;
                  cnt_d   = CNT_W'(MULT_LAT);
`ifdef MDU_DIV_EN
                  if ((op == MDU_DIV) || (op == MDU_DIVU)) begin
                     cnt_d = CNT_W'(DIV_LAT);
                  end
`endif
               end else if (op == MDU_MTHI) begin
                  hi_d = rs_val;
               end else if (op == MDU_MTLO) begin
                  lo_d = rs_val;
               end
            end
         end
         ST_RUN: begin
            if (cancel) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
               if ((op_q == MDU_MULT) || (op_q == MDU_MULTU)) begin
                  {hi_d, lo_d} = prod;
               end
`ifdef MDU_DIV_EN
               else if (!div_zero) begin
                  hi_d = rem;
                  lo_d = quot;
               end
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Stall looks at the live request so the D-stage op holds the same cycle
   assign stall  = md_use_d & (busy_q | (start & is_multicycle(op)));
   assign busy   = busy_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: arithmetic reference model plus directed vectors.
// Honours MDU_DIV_EN the same way as the design.
module tb_mdu_sequencer;

   localparam int unsigned MULT_LAT = 5;
   localparam int unsigned DIV_LAT  = 10;
`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        cancel;
   logic        md_use_d;
   logic        busy;
   logic        stall;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int n_checks = 0;
   int n_errors = 0;

   mdu_sequencer #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .cancel   (cancel),
      .md_use_d (md_use_d),
      .busy     (busy),
      .stall    (stall),
      .hi_out   (hi_out),
      .lo_out   (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remaining busy cycles, architectural HI/LO, pending result
   int          m_left;
   bit          m_wr;
   logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
   longint      sa, sb;
   logic [63:0] p;

   function automatic bit model_mc(input logic [2:0] o);
      return (o == 3'd1) || (o == 3'd2) || (DIV_EN && ((o == 3'd3) || (o == 3'd4)));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_wr   = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         m_rhi  = '0;
         m_rlo  = '0;
      end else if (m_left > 0) begin
         if (cancel) begin
            m_left = 0;
         end else begin
            m_left--;
            if (m_left == 0 && m_wr) begin
               m_hi = m_rhi;
               m_lo = m_rlo;
            end
         end
      end else if (start && !cancel) begin
         case (op)
            3'd1: begin
               p      = 64'(longint'($signed(rs_val)) * longint'($signed(rt_val)));
               m_rhi  = p[63:32];
               m_rlo  = p[31:0];
               m_wr   = 1'b1;
               m_left = MULT_LAT;
            end
            3'd2: begin
               p      = {32'd0, rs_val} * {32'd0, rt_val};
               m_rhi  = p[63:32];
               m_rlo  = p[31:0];
               m_wr   = 1'b1;
               m_left = MULT_LAT;
            end
            3'd3: if (DIV_EN) begin
               m_wr = (rt_val != 32'd0);
               if (m_wr) begin
                  sa    = longint'($signed(rs_val));
                  sb    = longint'($signed(rt_val));
                  m_rlo = 32'(sa / sb);
                  m_rhi = 32'(sa % sb);
               end
               m_left = DIV_LAT;
            end
            3'd4: if (DIV_EN) begin
               m_wr = (rt_val != 32'd0);
               if (m_wr) begin
                  m_rlo = rs_val / rt_val;
                  m_rhi = rs_val % rt_val;
               end
               m_left = DIV_LAT;
            end
            3'd5: m_hi = rs_val;
            3'd6: m_lo = rs_val;
            default: ;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", 32'(busy), 32'(m_left > 0));
         check("stall", 32'(stall), 32'(md_use_d && ((m_left > 0) || (start && model_mc(op)))));
         check("hi", hi_out, m_hi);
         check("lo", lo_out, m_lo);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      step();
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      step();
      start  = 1'b0;
      op     = 3'd0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         step();
      end
   endtask

   int n;
   int stall_cnt;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      op       = 3'd0;
      rs_val   = '0;
      rt_val   = '0;
      cancel   = 1'b0;
      md_use_d = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi_out, 32'd0);
      check("rst_lo", lo_out, 32'd0);
      #1 rst_n = 1'b1;

      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      check("mult_cycles", 32'(n), 32'd5);
      check("mult_hi", hi_out, 32'hFFFF_FFFF);
      check("mult_lo", lo_out, 32'hFFFF_FFFA);

      issue(3'd2, 32'h0001_0000, 32'h0001_0000);
      wait_idle(n);
      check("multu_cycles", 32'(n), 32'd5);
      check("multu_hi", hi_out, 32'd1);
      check("multu_lo", lo_out, 32'd0);

      issue(3'd5, 32'h1234, 32'd0);
      check("mthi_hi", hi_out, 32'h1234);
      check("mthi_busy", 32'(busy), 32'd0);
      issue(3'd6, 32'h5678, 32'd0);
      check("mtlo_lo", lo_out, 32'h5678);

`ifdef MDU_DIV_EN
      issue(3'd4, 32'd17, 32'd5);
      wait_idle(n);
      check("divu_cycles", 32'(n), 32'd10);
      check("divu_lo", lo_out, 32'd3);
      check("divu_hi", hi_out, 32'd2);

      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      check("div_lo", lo_out, 32'hFFFF_FFFD);
      check("div_hi", hi_out, 32'hFFFF_FFFF);

      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      check("div_ovf_lo", lo_out, 32'h8000_0000);
      check("div_ovf_hi", hi_out, 32'd0);

      issue(3'd5, 32'h1234, 32'd0);
      issue(3'd6, 32'h5678, 32'd0);
      issue(3'd3, 32'd5, 32'd0);
      wait_idle(n);
      check("div0_cycles", 32'(n), 32'd10);
      check("div0_hi", hi_out, 32'h1234);
      check("div0_lo", lo_out, 32'h5678);
`else
      issue(3'd4, 32'd17, 32'd5);
      wait_idle(n);
      check("nodiv_cycles", 32'(n), 32'd0);
      check("nodiv_hi", hi_out, 32'h1234);
      check("nodiv_lo", lo_out, 32'h5678);
`endif

      // Cancel in RUN cycle 3, then restart on the very next cycle
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      check("cancel_busy", 32'(busy), 32'd0);
      check("cancel_hi", hi_out, 32'h1234);
      check("cancel_lo", lo_out, 32'h5678);
      start  = 1'b1;
      op     = 3'd1;
      rs_val = 32'd2;
      rt_val = 32'd3;
      step();
      start  = 1'b0;
      op     = 3'd0;
      check("restart_busy", 32'(busy), 32'd1);
      wait_idle(n);
      check("restart_cycles", 32'(n), 32'd5);
      check("restart_lo", lo_out, 32'd6);
      check("restart_hi", hi_out, 32'd0);

      // Cancel together with start: nothing accepted
      step();
      start  = 1'b1;
      op     = 3'd2;
      cancel = 1'b1;
      step();
      start  = 1'b0;
      cancel = 1'b0;
      op     = 3'd0;
      check("cancel_start_busy", 32'(busy), 32'd0);

      // Reserved op behaves as NOP
      issue(3'd7, 32'hDEAD_BEEF, 32'd1);
      check("rsvd_busy", 32'(busy), 32'd0);
      check("rsvd_hi", hi_out, 32'd0);

      // Stall from an IDLE start and through RUN; a MULT start in RUN is ignored
      step();
      md_use_d = 1'b1;
      start    = 1'b1;
      op       = 3'd1;
      rs_val   = 32'd7;
      rt_val   = 32'hFFFF_FFFF;
      #1;
      check("stall_idle_start", 32'(stall), 32'd1);
      step();
      start     = 1'b0;
      op        = 3'd0;
      n         = 0;
      stall_cnt = 0;
      while (busy === 1'b1 && n < 200) begin
         if (stall === 1'b1) stall_cnt++;
         start  = (n == 1);
         op     = (n == 1) ? 3'd1 : 3'd0;
         rs_val = 32'd100;
         rt_val = 32'd100;
         n++;
         step();
      end
      start    = 1'b0;
      op       = 3'd0;
      md_use_d = 1'b0;
      check("stall_run_cycles", 32'(n), 32'd5);
      check("stall_run_count", 32'(stall_cnt), 32'd5);
      check("ignored_start_hi", hi_out, 32'hFFFF_FFFF);
      check("ignored_start_lo", lo_out, 32'hFFFF_FFF9);

      // Asynchronous reset in the middle of RUN
      issue(3'd1, 32'd5, 32'd5);
      step();
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_hi", hi_out, 32'd0);
      check("rst_mid_lo", lo_out, 32'd0);
      step();
      rst_n = 1'b1;
      issue(3'd2, 32'd3, 32'd4);
      wait_idle(n);
      check("post_rst_cycles", 32'(n), 32'd5);
      check("post_rst_lo", lo_out, 32'd12);
      check("post_rst_hi", hi_out, 32'd0);

      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
